// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int DEF_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_UDIV = 2'b01,
    OP_SDIV = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the operand buses, control unit and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::DEF_WIDTH);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (output Start, Op, OpA, OpB,
                  input  Result, Busy, Done, DivByZero);
  modport slave  (input  Start, Op, OpA, OpB,
                  output Result, Busy, Done, DivByZero);
endinterface

// File: rtl/muldiv_divu_step.sv
// One combinational iteration of restoring division.
module divu_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dvdBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {remIn, dvdBit};
  assign diff    = shifted - {1'b0, divisor};
  // remIn < divisor keeps the difference below 2^WIDTH, so bit WIDTH is a clean borrow
  assign qBit    = ~diff[WIDTH];
  assign remOut  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit MUL/UDIV/SDIV unit, one bit per cycle.
// Build option: MULDIV_SDIV_EN enables signed divide; otherwise Op=10 is reserved.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     Clk,
  input  logic     Reset,
  muldiv_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, stateNxt;
  op_e              opIn, opR;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accR;   // MUL accumulator / UDIV remainder
  logic [WIDTH-1:0] aR;     // multiplicand / dividend shifting into quotient
  logic [WIDTH-1:0] bR;     // multiplier / divisor
  logic [WIDTH-1:0] resR;
  logic             dbzR;

  logic             isDivIn, validIn, canStart, goRun, goFin, lastIter;
  logic [WIDTH-1:0] mulAcc, remOut, quoNext, finalRes;
  logic             qBit;

`ifdef MULDIV_SDIV_EN
  logic             negR;
  logic [WIDTH-1:0] absA, absB;
  assign absA = bus.OpA[WIDTH-1] ? -bus.OpA : bus.OpA;
  assign absB = bus.OpB[WIDTH-1] ? -bus.OpB : bus.OpB;
`endif

  assign opIn = op_e'(bus.Op);

  always_comb begin
    isDivIn = (opIn == OP_UDIV);
`ifdef MULDIV_SDIV_EN
    isDivIn = isDivIn || (opIn == OP_SDIV);
`endif
    validIn  = (opIn == OP_MUL) || isDivIn;
    canStart = bus.Start && (state != RUN);
    goRun    = canStart && validIn && !(isDivIn && (bus.OpB == '0));
    goFin    = canStart && !goRun;
    lastIter = (state == RUN) && (count == LAST);
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE, FIN: begin
        if (goRun)      stateNxt = RUN;
        else if (goFin) stateNxt = FIN;
        else            stateNxt = IDLE;
      end
      RUN:     if (lastIter) stateNxt = FIN;
      default: stateNxt = IDLE;
    endcase
  end

  divu_step #(.WIDTH(WIDTH)) uStep (
    .remIn   (accR),
    .dvdBit  (aR[WIDTH-1]),
    .divisor (bR),
    .remOut  (remOut),
    .qBit    (qBit)
  );

  always_comb begin
    mulAcc  = accR + (bR[0] ? aR : '0);
    quoNext = {aR[WIDTH-2:0], qBit};
    if (opR == OP_MUL) finalRes = mulAcc;
    else               finalRes = quoNext;
`ifdef MULDIV_SDIV_EN
    // magnitude quotient gets its sign back; MIN / -1 wraps to MIN by itself
    if (opR == OP_SDIV && negR) finalRes = -quoNext;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      opR   <= OP_MUL;
      count <= '0;
      accR  <= '0;
      aR    <= '0;
      bR    <= '0;
      resR  <= '0;
      dbzR  <= 1'b0;
`ifdef MULDIV_SDIV_EN
      negR  <= 1'b0;
`endif
    end else begin
      state <= stateNxt;
      if (goRun) begin
        opR   <= opIn;
        count <= '0;
        accR  <= '0;
        aR    <= bus.OpA;
        bR    <= bus.OpB;
        dbzR  <= 1'b0;
`ifdef MULDIV_SDIV_EN
        negR  <= 1'b0;
        if (opIn == OP_SDIV) begin
          aR   <= absA;
          bR   <= absB;
          negR <= bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1];
        end
`endif
      end else if (goFin) begin
        resR <= '0;
        dbzR <= isDivIn;
      end else if (state == RUN) begin
        count <= count + 1'b1;
        if (opR == OP_MUL) begin
          accR <= mulAcc;
          aR   <= aR << 1;
          bR   <= bR >> 1;
        end else begin
          accR <= remOut;
          aR   <= quoNext;
        end
        if (lastIter) resR <= finalRes;
      end
    end
  end

  assign bus.Result    = resR;
  assign bus.DivByZero = dbzR;
  assign bus.Busy      = (state == RUN);
  assign bus.Done      = (state == FIN);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand sequences, random vs. arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int nChecks = 0;
  int nErr    = 0;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
    bit           pulses;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the operation definitions
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic dbz, output int lat);
    res = '0; dbz = 1'b0; lat = 0;
    case (op)
      2'b00: begin res = a * b; lat = W; end
      2'b01: if (b == 0) dbz = 1'b1; else begin res = a / b; lat = W; end
`ifdef MULDIV_SDIV_EN
      2'b10: begin
        if (b == 0) dbz = 1'b1;
        else begin
          lat = W;
          if (a == MINV && b == ONES) res = MINV;
          else res = $signed(a) / $signed(b);
        end
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int expLat, input logic [W-1:0] expRes,
                          input logic expDbz, input bit pulses);
    logic [W-1:0] held;
    int lat;
    bit busyBad, resMoved;
    held = bus.Result; lat = 0; busyBad = 0; resMoved = 0;
    while (!bus.Done && lat < 200) begin
      if (bus.Busy !== 1'b1) busyBad = 1;
      if (bus.Result !== held) resMoved = 1;
      bus.Start = pulses && (lat == 10 || lat == 40);
      bus.Op  = 2'b00;
      bus.OpA = {$urandom, $urandom};
      bus.OpB = {$urandom, $urandom};
      @(posedge Clk); #1;
      lat++;
    end
    bus.Start = 1'b0;
    chk({name, " latency"}, W'(lat), W'(expLat));
    chk({name, " result"}, bus.Result, expRes);
    chk({name, " divbyzero"}, W'(bus.DivByZero), W'(expDbz));
    chk({name, " busy at done"}, W'(bus.Busy), '0);
    chk({name, " busy during run"}, W'(busyBad), '0);
    chk({name, " result held in run"}, W'(resMoved), '0);
  endtask

  task automatic oneShot(input string name, input logic [W-1:0] expRes);
    @(posedge Clk); #1;
    chk({name, " done one cycle"}, W'(bus.Done), '0);
    chk({name, " result held"}, bus.Result, expRes);
  endtask

  initial begin
    logic [W-1:0] a, b, res;
    logic dbz;
    int lat;
    bit sawDone;

    vecs.push_back('{"mul3x5",   2'b00, 3, 5, 15, 0, W, 0});
    vecs.push_back('{"mulwrap",  2'b00, ONES, 2, ONES - 1, 0, W, 0});
    vecs.push_back('{"udiv100",  2'b01, 100, 7, 14, 0, W, 1});
    vecs.push_back('{"udiv0",    2'b01, 55, 0, 0, 1, 0, 0});
    vecs.push_back('{"mulzero",  2'b00, 0, 12345, 0, 0, W, 0});
    vecs.push_back('{"rsvd",     2'b11, 3, 9, 0, 0, 0, 0});
    vecs.push_back('{"udivmax",  2'b01, ONES, 1, ONES, 0, W, 0});
    vecs.push_back('{"udivsmall",2'b01, 6, 7, 0, 0, W, 0});
`ifdef MULDIV_SDIV_EN
    vecs.push_back('{"sdivneg",  2'b10, -64'sd100, 7, -64'sd14, 0, W, 0});
    vecs.push_back('{"sdivmin",  2'b10, MINV, ONES, MINV, 0, W, 0});
    vecs.push_back('{"sdivnn",   2'b10, -64'sd100, -64'sd7, 14, 0, W, 0});
    vecs.push_back('{"sdiv0",    2'b10, 7, 0, 0, 1, 0, 0});
`else
    vecs.push_back('{"sdivoff",  2'b10, -64'sd100, 7, 0, 0, 0, 0});
`endif

    bus.Start = 1'b0; bus.Op = 2'b00; bus.OpA = '0; bus.OpB = '0;
    Reset = 1'b1;
    #2;
    chk("reset result", bus.Result, '0);
    chk("reset busy", W'(bus.Busy), '0);
    chk("reset done", W'(bus.Done), '0);
    chk("reset dbz", W'(bus.DivByZero), '0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(vecs[i].name, vecs[i].lat, vecs[i].res, vecs[i].dbz, vecs[i].pulses);
      oneShot(vecs[i].name, vecs[i].res);
    end

    // back-to-back: next Start lands while the first op sits in FIN
    issue(2'b01, 100, 7);
    waitDone("b2b first", W, 14, 0, 0);
    issue(2'b00, 6, 7);
    waitDone("b2b second", W, 42, 0, 0);
    oneShot("b2b second", 42);

    // divide-by-zero flag cleared by the next accepted op
    issue(2'b01, 9, 0);
    waitDone("dbz set", 0, 0, 1, 0);
    issue(2'b00, 2, 2);
    waitDone("dbz cleared", W, 4, 0, 0);

    // reset mid-run aborts with no Done
    issue(2'b00, 64'h1234_5678, 64'h9abc);
    repeat (29) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("midreset result", bus.Result, '0);
    chk("midreset busy", W'(bus.Busy), '0);
    chk("midreset done", W'(bus.Done), '0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    sawDone = 0;
    repeat (100) begin
      @(posedge Clk); #1;
      if (bus.Done || bus.Busy) sawDone = 1;
    end
    chk("midreset no done", W'(sawDone), '0);
    issue(2'b00, 6, 7);
    waitDone("after reset", W, 42, 0, 0);
    oneShot("after reset", 42);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: a = W'($urandom_range(0, 1000));
        default: ;
      endcase
      model(2'($urandom_range(0, 3)), a, b, res, dbz, lat);
      begin
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        model(op, a, b, res, dbz, lat);
        issue(op, a, b);
        waitDone($sformatf("rand%0d op%0d", i, op), lat, res, dbz, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end
endmodule
